// File: rtl/cache_request_arbiter.sv
// cache_request_arbiter: round-robin arbiter that shares the single cache
// controller request path between NUM_REQ CPU-side requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional watchdog on the WAIT state: define CACHE_ARB_WATCHDOG_EN.
module cache_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             req_err,
  output logic                             ctrl_request,
  output logic                             ctrl_read,
  output logic                             ctrl_write,
  output logic [ADDRESS_WIDTH-1:0]         ctrl_addr,
  output logic [DATA_WIDTH-1:0]            ctrl_wdata,
  input  logic                             ctrl_done,
  input  logic [DATA_WIDTH-1:0]            ctrl_rdata,
  output logic                             busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PTR_W-1:0]           r_rr_ptr;
  logic [PTR_W-1:0]           r_winner;
  logic                       r_write;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]      r_wdata;
  logic [DATA_WIDTH-1:0]      r_rdata;

  logic                       w_found;
  logic [PTR_W-1:0]           w_grant;
  int                         w_idx;
  logic                       w_active;
  logic                       w_timeout;

`ifdef CACHE_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]            r_wd_cnt;
  logic                       r_err;

  // Watchdog fires on the WAIT cycle in which the count reaches the limit.
  assign w_timeout = (r_state == S_WAIT) &&
                     ((r_wd_cnt + WD_W'(1)) == WD_W'(TIMEOUT_CYCLES));

  // Watchdog counter: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Error flag: set on timeout exit from WAIT, cleared on a normal completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (ctrl_done)      r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
    end
  end

  assign req_err = (r_state == S_RESP) && r_err;
`else
  // Watchdog limit has no effect in this build.
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
  assign req_err   = 1'b0;
`endif

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_grant = PTR_W'(w_idx);
      end
    end
  end

  // Next-state logic; a ctrl_done outside WAIT is simply ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (ctrl_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Command latch at grant; held untouched until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_winner <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_winner <= w_grant;
      r_write  <= req_write[w_grant];
      r_addr   <= req_addr[w_grant*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      r_wdata  <= req_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read data capture; a timeout returns zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == S_WAIT) begin
      if (ctrl_done)      r_rdata <= ctrl_rdata;
      else if (w_timeout) r_rdata <= '0;
    end
  end

  // Priority pointer moves just past the winner when its response goes out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (r_state == S_RESP) begin
      r_rr_ptr <= (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + PTR_W'(1);
    end
  end

  // Controller-side outputs: latched command visible from ISSUE through RESP.
  assign w_active     = (r_state != S_IDLE);
  assign busy         = w_active;
  assign ctrl_request = (r_state == S_ISSUE);
  assign ctrl_read    = w_active && !r_write;
  assign ctrl_write   = w_active && r_write;
  assign ctrl_addr    = w_active ? r_addr  : '0;
  assign ctrl_wdata   = w_active ? r_wdata : '0;
  assign req_rdata    = (r_state == S_RESP) ? r_rdata : '0;

  // One-hot completion strobe to the winner during RESP.
  always_comb begin
    req_done = '0;
    if (r_state == S_RESP) req_done[r_winner] = 1'b1;
  end

endmodule

// File: doc/cache_request_arbiter.md
Name: cache_request_arbiter

Overview:
- Round-robin arbiter sharing the single cache controller request path between NUM_REQ CPU-side requesters (e.g. fetch port, load/store port).
- Latches the winning requester's command (read/write, address, write data) and issues it to the controller as a one-cycle request pulse.
- Waits for controller completion, then routes the done strobe and read data back to the winner.
- Sits directly upstream of the cache controller's request interface.

Parameters:
- NUM_REQ, 2, number of requesters; must be >= 2.
- ADDRESS_WIDTH, 32, request address width.
- DATA_WIDTH, 32, read/write data width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until the matching req_done.
- req_write  input  NUM_REQ  per-requester command: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDRESS_WIDTH  flattened addresses; requester i occupies bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- req_done  output  NUM_REQ  one-hot, single-cycle completion strobe to the winner.
- req_rdata  output  DATA_WIDTH  read data; valid only while req_done is high.
- req_err  output  1  error flag; valid with req_done; always 0 without the optional feature.
- ctrl_request  output  1  one-cycle request pulse to the controller.
- ctrl_read  output  1  latched command is a read.
- ctrl_write  output  1  latched command is a write.
- ctrl_addr  output  ADDRESS_WIDTH  latched address.
- ctrl_wdata  output  DATA_WIDTH  latched write data.
- ctrl_done  input  1  controller completion pulse.
- ctrl_rdata  input  DATA_WIDTH  controller read data; valid with ctrl_done.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Go to ISSUE if req != 0.
  - Winner is the first set bit found by searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner index plus its command, address and write data into internal registers.
- ISSUE:
  - ctrl_request = 1 for exactly this cycle.
  - ctrl_read/ctrl_write are driven from the latched command.
  - Always go to WAIT next.
- WAIT:
  - On ctrl_done: capture ctrl_rdata and go to RESP.
  - A ctrl_done seen in any other state is ignored.
- RESP:
  - req_done[winner] = 1 and req_rdata = captured data, for one cycle.
  - rr_ptr <= (winner == NUM_REQ-1) ? 0 : winner+1.
  - Go to IDLE.
- Output timing:
  - ctrl_read, ctrl_write, ctrl_addr and ctrl_wdata stay stable from ISSUE through RESP.
  - All four are 0 in IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle N -> ctrl_request at cycle N+1.
  - ctrl_done at cycle M -> req_done at cycle M+1.
  - Minimum issue spacing is 4 cycles, because RESP always returns to IDLE.
- Fairness: a continuously asserted request is granted within NUM_REQ transactions.
- Requester rules:
  - The latched command is used for the whole transaction; changes to req_addr/req_wdata after the grant are ignored.
  - If req drops while that requester is being serviced, the transaction still completes and req_done is still pulsed.
  - The requester that just finished may re-request immediately; it is arbitrated fresh in IDLE at its new, lowest priority.
- Reset:
  - State = IDLE, rr_ptr = 0, winner = 0.
  - All outputs 0; latched command and data registers cleared.
  - Reset during WAIT abandons the transaction with no req_done. The controller is also reset with the same signal.
- Width rules:
  - rr_ptr and winner are $clog2(NUM_REQ) bits.
  - Wrap is explicit compare-to-NUM_REQ-1, so non-power-of-two NUM_REQ is correct.

Optional Feature:
- Macro: CACHE_ARB_WATCHDOG_EN.
- With the macro defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without ctrl_done: go to RESP with req_err = 1 and req_rdata = 0. rr_ptr still advances.
  - ctrl_done arriving in the same cycle as the limit wins; req_err = 0.
- Without the macro: no counter, req_err tied to 0, WAIT has no timeout.

Test Plan:
- Single read:
  - Stimulus: NUM_REQ=2; req=2'b01, read, addr 0x0000_1040; ctrl_done after 3 WAIT cycles with ctrl_rdata=0xDEADBEEF.
  - Response: ctrl_request pulses 1 cycle after req with ctrl_addr=0x0000_1040 and ctrl_read=1; req_done=2'b01 and req_rdata=0xDEADBEEF 1 cycle after ctrl_done.
- Contention: both requesters held high for 4 transactions -> grants alternate 0, 1, 0, 1 after reset.
- Write latch:
  - Stimulus: req1 write, addr 0x20, wdata 0x1234_5678; change req_addr to 0x99 during WAIT.
  - Response: ctrl_addr stays 0x20 and ctrl_wdata stays 0x1234_5678 until RESP.
- Non-power-of-two wrap: NUM_REQ=3, all requesting -> grant order 0, 1, 2, 0; rr_ptr returns to 0 after winner 2.
- Reset mid-transaction: assert reset in WAIT -> next cycle busy=0, ctrl_* all 0, no req_done, next grant goes to requester 0.
- Watchdog (CACHE_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8):
  - No ctrl_done -> req_done together with req_err=1 exactly 9 cycles after ctrl_request.
  - With the macro undefined, the bench stays in WAIT for 100 cycles with busy=1.
